// File: rtl/mem_pkg.sv
// Shared definitions for the load/store path: default widths, memctrl
// encodings, access sizes and the load/store FSM states.
package mem_pkg;

  localparam int WD_DEFAULT  = 32;
  localparam int WAM_DEFAULT = 17;

  typedef enum logic [2:0] {
    MC_WORD    = 3'b000,
    MC_HALF_S  = 3'b001,
    MC_BYTE_ST = 3'b010,
    MC_BYTE_U  = 3'b011,
    MC_BYTE_S  = 3'b100,
    MC_HALF_U  = 3'b101
  } memctrl_e;

  typedef enum logic [1:0] {
    SZ_WORD,
    SZ_HALF,
    SZ_BYTE
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  // 110 and 111 are unassigned and fall back to a word access.
  function automatic size_e ctrl_size(input logic [2:0] ctrl);
    case (memctrl_e'(ctrl))
      MC_HALF_S, MC_HALF_U:             return SZ_HALF;
      MC_BYTE_ST, MC_BYTE_U, MC_BYTE_S: return SZ_BYTE;
      default:                          return SZ_WORD;
    endcase
  endfunction

  function automatic logic ctrl_signed(input logic [2:0] ctrl);
    return (ctrl == MC_HALF_S) || (ctrl == MC_BYTE_S);
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte or half out of a read word and sign- or
// zero-extends it to the full data width.
module load_align
  import mem_pkg::*;
#(
  parameter int WD = WD_DEFAULT
) (
  input  logic [WD-1:0] rdata,
  input  logic [1:0]    addr_lo,
  input  size_e         size,
  input  logic          sign_ext,
  output logic [WD-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // NOTE: every output of a combinational block gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    byte_v = rdata[{addr_lo, 3'b000} +: 8];
    half_v = rdata[{addr_lo[1], 4'b0000} +: 16];
    data   = rdata;
    case (size)
      SZ_HALF: data = {{(WD-16){sign_ext & half_v[15]}}, half_v};
      SZ_BYTE: data = {{(WD-8){sign_ext & byte_v[7]}}, byte_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// M-stage load/store unit: latches one access, holds a request to memory
// until it is acknowledged, then releases the pipeline for one DONE cycle.
module load_store_unit
  import mem_pkg::*;
#(
  parameter int WD  = WD_DEFAULT,
  parameter int WAM = WAM_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memreadM,
  input  logic          memwriteM,
  input  logic [2:0]    memctrlM,
  input  logic [WD-1:0] aluresultM,
  input  logic [WD-1:0] writedataM,
  output logic [WD-1:0] readdataM,
  output logic          stallM,
  output logic          misalignM,
  output logic          mem_req,
  output logic          mem_we,
  output logic [WAM:0]  mem_addr,
  output logic [WD-1:0] mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic          mem_ready,
  input  logic [WD-1:0] mem_rdata
);

  state_e        state;
  logic          we_q;
  size_e         size_q;
  logic          sign_q;
  logic [1:0]    lo_q;
  logic [WAM:2]  word_addr_q;
  logic [WD-1:0] wdata_q;
  logic [3:0]    wstrb_q;
  logic [WD-1:0] result_q;

  size_e         size_d;
  logic          access;
  logic          misaligned;
  logic          accept;
  logic [3:0]    wstrb_d;
  logic [WD-1:0] wdata_d;
  logic [WD-1:0] load_data;

  // Address bits above WAM wrap away by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^aluresultM[WD-1:WAM+1];

  always_comb begin
    size_d     = ctrl_size(memctrlM);
    access     = memreadM | memwriteM;
    misaligned = 1'b0;
    wstrb_d    = 4'b1111;
    wdata_d    = writedataM;
    case (size_d)
      SZ_HALF: begin
        misaligned = aluresultM[0];
        wstrb_d    = 4'b0011 << aluresultM[1:0];
        wdata_d    = {(WD/16){writedataM[15:0]}};
      end
      SZ_BYTE: begin
        wstrb_d = 4'b0001 << aluresultM[1:0];
        wdata_d = {(WD/8){writedataM[7:0]}};
      end
      default: misaligned = |aluresultM[1:0];
    endcase
    accept = (state == IDLE) && access && !misaligned;
  end

  assign stallM    = accept || (state == BUSY);
  assign misalignM = (state == IDLE) && access && misaligned;
  assign mem_req   = (state == BUSY);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = {word_addr_q, 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wstrb = mem_req ? wstrb_q : 4'b0000;
  assign readdataM = (state == DONE) ? result_q : '0;

  load_align #(.WD(WD)) u_align (
    .rdata    (mem_rdata),
    .addr_lo  (lo_q),
    .size     (size_q),
    .sign_ext (sign_q),
    .data     (load_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values. Only control state is reset; the latched
  // address and data are always rewritten before they are used.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      result_q <= '0;
      we_q     <= 1'b0;
      wstrb_q  <= 4'b0000;
    end else begin
      case (state)
        IDLE: if (accept) begin
          we_q        <= memwriteM;
          size_q      <= size_d;
          sign_q      <= ctrl_signed(memctrlM);
          lo_q        <= aluresultM[1:0];
          word_addr_q <= aluresultM[WAM:2];
          wdata_q     <= wdata_d;
          wstrb_q     <= wstrb_d;
          state       <= BUSY;
        end
        BUSY: if (mem_ready) begin
          // A combined read+write is a store and returns nothing.
          result_q <= we_q ? '0 : load_data;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized accesses
// checked against an arithmetic model of sizes, lanes and latency.
module tb_load_store_unit;

  localparam int WD  = 32;
  localparam int WAM = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          memreadM, memwriteM;
  logic [2:0]    memctrlM;
  logic [WD-1:0] aluresultM, writedataM;
  logic [WD-1:0] readdataM;
  logic          stallM, misalignM;
  logic          mem_req, mem_we;
  logic [WAM:0]  mem_addr;
  logic [WD-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ready;
  logic [WD-1:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.WD(WD), .WAM(WAM)) dut (
    .clk        (clk),
    .rst        (rst),
    .memreadM   (memreadM),
    .memwriteM  (memwriteM),
    .memctrlM   (memctrlM),
    .aluresultM (aluresultM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .stallM     (stallM),
    .misalignM  (misalignM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  // Observations gathered by run_access for the calling test to judge.
  int           o_stalls;
  logic         o_mis, o_req_seen, o_we, o_stable, o_timeout, o_req_in_done, o_early_rd;
  logic [WAM:0] o_addr;
  logic [31:0]  o_wdata, o_rd;
  logic [3:0]   o_wstrb;

  // Presents one access from a negedge and plays the memory: mem_ready is
  // raised after `delay` request cycles. Returns at a negedge, inputs idle.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] ctrl,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int delay);
    int busy = 0;
    bit done = 0;
    memreadM = rd; memwriteM = wr; memctrlM = ctrl;
    aluresultM = addr; writedataM = wdata; mem_ready = 1'b0;
    o_stalls = 0; o_mis = 0; o_req_seen = 0; o_we = 0; o_stable = 1;
    o_timeout = 0; o_req_in_done = 0; o_early_rd = 0;
    o_addr = '0; o_wdata = '0; o_rd = '0; o_wstrb = '0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (cyc == 0) o_mis = misalignM;
      if (mem_req === 1'b1) begin
        if (!o_req_seen) begin
          o_req_seen = 1; o_addr = mem_addr; o_we = mem_we;
          o_wdata = mem_wdata; o_wstrb = mem_wstrb;
        end else if (mem_addr !== o_addr || mem_we !== o_we ||
                     mem_wdata !== o_wdata || mem_wstrb !== o_wstrb) begin
          o_stable = 0;
        end
        mem_ready = (busy == delay);
        mem_rdata = (busy == delay) ? rdata : $urandom;
        busy++;
      end else begin
        mem_ready = 1'b0;
      end
      if (stallM === 1'b1) begin
        o_stalls++;
        if (readdataM !== '0) o_early_rd = 1;
      end else begin
        o_rd = readdataM; o_req_in_done = mem_req; done = 1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (!done) o_timeout = 1;
    memreadM = 1'b0; memwriteM = 1'b0; mem_ready = 1'b0;
  endtask

  // Reference model: access size from memctrl (0 word, 1 half, 2 byte).
  function automatic int model_size(input logic [2:0] c);
    if (c == 3'd1 || c == 3'd5) return 1;
    if (c == 3'd2 || c == 3'd3 || c == 3'd4) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] c, input logic [31:0] a,
                                             input logic [31:0] rdata);
    logic [31:0] v;
    int lo = int'(a % 4);
    case (model_size(c))
      1: begin
        v = (rdata >> (16 * (lo / 2))) & 32'h0000_FFFF;
        if (c == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
      end
      2: begin
        v = (rdata >> (8 * lo)) & 32'h0000_00FF;
        if (c == 3'd4 && v >= 32'h80) v = v + 32'hFFFF_FF00;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; memreadM = 0; memwriteM = 0; memctrlM = 0;
    aluresultM = 0; writedataM = 0; mem_ready = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b expected 0", mem_req); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b expected 0", mem_we); end
    total++; if (mem_wstrb !== 4'b0) begin bad++; $display("FAIL reset_wstrb: got %b expected 0000", mem_wstrb); end
    total++; if (stallM !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b expected 0", stallM); end
    total++; if (misalignM !== 1'b0) begin bad++; $display("FAIL reset_misalign: got %b expected 0", misalignM); end
    total++; if (readdataM !== '0) begin bad++; $display("FAIL reset_rdata: got %h expected 0", readdataM); end
    @(negedge clk);
  endtask

  task automatic test_lw();
    run_access(1, 0, 3'b000, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    total++; if (o_timeout !== 1'b0) begin bad++; $display("FAIL lw_timeout: got %b expected 0", o_timeout); end
    total++; if (o_stalls !== 2) begin bad++; $display("FAIL lw_stalls: got %0d expected 2", o_stalls); end
    total++; if (o_rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_data: got %h expected deadbeef", o_rd); end
    total++; if (o_addr !== 18'h100) begin bad++; $display("FAIL lw_addr: got %h expected 100", o_addr); end
    total++; if (o_we !== 1'b0) begin bad++; $display("FAIL lw_we: got %b expected 0", o_we); end
    total++; if (o_req_in_done !== 1'b0) begin bad++; $display("FAIL lw_req_done: got %b expected 0", o_req_in_done); end
    total++; if (o_early_rd !== 1'b0) begin bad++; $display("FAIL lw_early_rdata: got %b expected 0", o_early_rd); end
  endtask

  task automatic test_lb();
    run_access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 0);
    total++; if (o_rd !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_data: got %h expected ffffff80", o_rd); end
    run_access(1, 0, 3'b011, 32'h103, 32'h0, 32'h80FF_0000, 1);
    total++; if (o_rd !== 32'h0000_0080) begin bad++; $display("FAIL lbu_data: got %h expected 00000080", o_rd); end
    total++; if (o_stalls !== 3) begin bad++; $display("FAIL lbu_stalls: got %0d expected 3", o_stalls); end
  endtask

  task automatic test_sh();
    run_access(0, 1, 3'b001, 32'h102, 32'h1234_ABCD, 32'h5555_5555, 3);
    total++; if (o_wstrb !== 4'b1100) begin bad++; $display("FAIL sh_wstrb: got %b expected 1100", o_wstrb); end
    total++; if (o_wdata !== 32'hABCD_ABCD) begin bad++; $display("FAIL sh_wdata: got %h expected abcdabcd", o_wdata); end
    total++; if (o_stalls !== 5) begin bad++; $display("FAIL sh_stalls: got %0d expected 5", o_stalls); end
    total++; if (o_we !== 1'b1) begin bad++; $display("FAIL sh_we: got %b expected 1", o_we); end
    total++; if (o_stable !== 1'b1) begin bad++; $display("FAIL sh_stable: got %b expected 1", o_stable); end
    total++; if (o_rd !== '0) begin bad++; $display("FAIL sh_rdata: got %h expected 0", o_rd); end
    // Read and write together behave as a store and return zero.
    run_access(1, 1, 3'b000, 32'h104, 32'hCAFE_F00D, 32'h1111_1111, 1);
    total++; if (o_we !== 1'b1) begin bad++; $display("FAIL rw_we: got %b expected 1", o_we); end
    total++; if (o_rd !== '0) begin bad++; $display("FAIL rw_rdata: got %h expected 0", o_rd); end
    total++; if (o_wdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL rw_wdata: got %h expected cafef00d", o_wdata); end
  endtask

  task automatic test_misalign();
    run_access(1, 0, 3'b000, 32'h101, 32'h0, 32'h0, 0);
    total++; if (o_mis !== 1'b1) begin bad++; $display("FAIL lw_mis_flag: got %b expected 1", o_mis); end
    total++; if (o_stalls !== 0) begin bad++; $display("FAIL lw_mis_stall: got %0d expected 0", o_stalls); end
    total++; if (o_req_seen !== 1'b0) begin bad++; $display("FAIL lw_mis_req: got %b expected 0", o_req_seen); end
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL lw_mis_req_after: got %b expected 0", mem_req); end
    run_access(0, 1, 3'b101, 32'h203, 32'h0, 32'h0, 0);
    total++; if (o_mis !== 1'b1) begin bad++; $display("FAIL sh_mis_flag: got %b expected 1", o_mis); end
    total++; if (o_req_seen !== 1'b0) begin bad++; $display("FAIL sh_mis_req: got %b expected 0", o_req_seen); end
  endtask

  task automatic test_addr_wrap();
    run_access(1, 0, 3'b111, 32'hFFFF_FFFC, 32'h0, 32'h0BAD_F00D, 0);
    total++; if (o_addr !== 18'h3FFFC) begin bad++; $display("FAIL wrap_addr: got %h expected 3fffc", o_addr); end
    total++; if (o_rd !== 32'h0BAD_F00D) begin bad++; $display("FAIL wrap_data: got %h expected 0badf00d", o_rd); end
    run_access(0, 1, 3'b010, 32'h0004_000A, 32'h0000_00A5, 32'h0, 0);
    total++; if (o_addr !== 18'h00008) begin bad++; $display("FAIL wrap_addr2: got %h expected 00008", o_addr); end
    total++; if (o_wstrb !== 4'b0100) begin bad++; $display("FAIL sb_wstrb: got %b expected 0100", o_wstrb); end
    total++; if (o_wdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", o_wdata); end
  endtask

  task automatic test_reset_busy();
    memreadM = 1; memwriteM = 0; memctrlM = 3'b000; aluresultM = 32'h200; mem_ready = 0;
    @(negedge clk);
    #1;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rstbusy_req: got %b expected 1", mem_req); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; memreadM = 0; mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rstbusy_req_off: got %b expected 0", mem_req); end
    total++; if (stallM !== 1'b0) begin bad++; $display("FAIL rstbusy_stall: got %b expected 0", stallM); end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    total++; if (readdataM !== '0) begin bad++; $display("FAIL rstbusy_rdata: got %h expected 0", readdataM); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rstbusy_req_late: got %b expected 0", mem_req); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [2:0]  c;
    logic [31:0] a, wd, rdv, exp_rd, exp_wd;
    logic [3:0]  exp_strb;
    logic        rd, wr, mis;
    int          dly, sz, lo;
    for (int n = 0; n < 60; n++) begin
      wr = $urandom_range(0, 1);
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      c  = 3'($urandom_range(0, 7));
      if (!wr && c == 3'b010) c = 3'b011;
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC | 32'(n % 4) & (c == 0 || c > 5 ? 32'h0 : 32'h2 | 32'(c > 1 && c < 5));
      wd = $urandom; rdv = $urandom; dly = $urandom_range(0, 3);
      sz = model_size(c); lo = int'(a % 4);
      mis = (sz == 0 && lo != 0) || (sz == 1 && (lo % 2) != 0);
      run_access(rd, wr, c, a, wd, rdv, dly);
      total++; if (o_mis !== mis) begin bad++; $display("FAIL rnd%0d_mis: got %b expected %b", n, o_mis, mis); end
      if (mis) begin
        total++; if (o_req_seen !== 1'b0) begin bad++; $display("FAIL rnd%0d_mis_req: got %b expected 0", n, o_req_seen); end
      end else begin
        exp_rd = wr ? 32'h0 : model_load(c, a, rdv);
        total++; if (o_stalls !== 2 + dly) begin bad++; $display("FAIL rnd%0d_stalls: got %0d expected %0d", n, o_stalls, 2 + dly); end
        total++; if (o_addr !== 18'(a % 32'h40000 / 4 * 4)) begin bad++; $display("FAIL rnd%0d_addr: got %h expected %h", n, o_addr, a % 32'h40000 / 4 * 4); end
        total++; if (o_we !== wr) begin bad++; $display("FAIL rnd%0d_we: got %b expected %b", n, o_we, wr); end
        total++; if (o_rd !== exp_rd) begin bad++; $display("FAIL rnd%0d_rdata: got %h expected %h", n, o_rd, exp_rd); end
        total++; if (o_stable !== 1'b1 || o_req_in_done !== 1'b0 || o_early_rd !== 1'b0) begin
          bad++; $display("FAIL rnd%0d_handshake: got stable=%b req_done=%b early=%b expected 1 0 0",
                          n, o_stable, o_req_in_done, o_early_rd);
        end
        if (wr) begin
          exp_strb = (sz == 0) ? 4'hF : (sz == 1) ? 4'(3 << lo) : 4'(1 << lo);
          exp_wd   = (sz == 0) ? wd : (sz == 1) ? (wd % 32'h10000) * 32'h10001
                                                : (wd % 32'h100) * 32'h01010101;
          total++; if (o_wstrb !== exp_strb) begin bad++; $display("FAIL rnd%0d_wstrb: got %b expected %b", n, o_wstrb, exp_strb); end
          total++; if (o_wdata !== exp_wd) begin bad++; $display("FAIL rnd%0d_wdata: got %h expected %h", n, o_wdata, exp_wd); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb();
    test_sh();
    test_misalign();
    test_addr_wrap();
    test_reset_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WD, default 32, meaning data word width in bits.
REQ-002 SHALL have parameter WAM, default 17, meaning top index of the memory byte address; the memory address is WAM+1 bits.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning reset; synchronous and active-high.
REQ-005 SHALL have port memreadM, input, 1 bit, meaning a load is in the M stage.
REQ-006 SHALL have port memwriteM, input, 1 bit, meaning a store is in the M stage.
REQ-007 SHALL have port memctrlM, input, 3 bits, meaning access size and sign (encoding per REQ-034).
REQ-008 SHALL have port aluresultM, input, WD bits, meaning the byte address.
REQ-009 SHALL have port writedataM, input, WD bits, meaning store data, right-aligned.
REQ-010 SHALL have port readdataM, output, WD bits, meaning aligned and extended load result.
REQ-011 SHALL have port stallM, output, 1 bit, meaning freeze the pipeline while high.
REQ-012 SHALL have port misalignM, output, 1 bit, meaning the current access is misaligned and is not performed.
REQ-013 SHALL have port mem_req, output, 1 bit, meaning a request is valid toward memory.
REQ-014 SHALL have port mem_we, output, 1 bit, meaning the request is a write.
REQ-015 SHALL have port mem_addr, output, WAM+1 bits, meaning the word-aligned address; bits [1:0] are always 0.
REQ-016 SHALL have port mem_wdata, output, WD bits, meaning lane-placed write data.
REQ-017 SHALL have port mem_wstrb, output, 4 bits, meaning byte-lane write enables.
REQ-018 SHALL have port mem_ready, input, 1 bit, meaning memory completes the request this cycle.
REQ-019 SHALL have port mem_rdata, input, WD bits, meaning the read word; valid when mem_ready is high.

Function
REQ-020 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-021 In IDLE, on an aligned access (memreadM or memwriteM high), SHALL assert stallM combinationally, latch address, control, lanes and data, and go to BUSY.
REQ-022 In BUSY, SHALL hold mem_req=1 and keep mem_we, mem_addr, mem_wdata and mem_wstrb stable until the cycle where mem_ready=1.
REQ-023 In BUSY, SHALL keep stallM=1.
REQ-024 In BUSY, on mem_ready=1, SHALL register the extracted load result and go to DONE; mem_req SHALL be 0 in the following cycle.
REQ-025 In DONE, SHALL drive stallM=0 and readdataM=registered result, and go to IDLE unconditionally; the same instruction SHALL NOT be reissued.
REQ-026 Minimum latency SHALL be 3 cycles (IDLE, BUSY with ready, DONE); each cycle of mem_ready=0 in BUSY SHALL add one cycle.
REQ-027 When memreadM and memwriteM are both high, the access SHALL be treated as a store, and readdataM SHALL be 0 in DONE.
REQ-028 A word access with addr[1:0]!=0, or a half access with addr[0]=1, SHALL assert misalignM in IDLE combinationally, with stallM=0, no request and no state change.
REQ-029 For a store, mem_wstrb SHALL be 1111 for a word, 0011<<addr[1:0] for a half, and 0001<<addr[1:0] for a byte.
REQ-030 For a store, mem_wdata SHALL replicate the byte to all four lanes, the half to both halves, or pass the word unchanged.
REQ-031 For a load, SHALL select byte rdata[8*a+7:8*a] or half rdata[16*a1+15:16*a1], where a=addr[1:0] and a1=addr[1], then sign- or zero-extend per memctrlM.
REQ-032 readdataM SHALL be 0 in every state other than DONE.
REQ-033 mem_addr SHALL be aluresultM[WAM:2] concatenated with 00; address bits above WAM SHALL be ignored, and the address wraps modulo 2^(WAM+1).
REQ-034 memctrlM encoding SHALL be: 000 word, 001 half signed, 010 byte store, 011 byte unsigned load, 100 byte signed, 101 half unsigned; 110 and 111 SHALL act as word.

Reset
REQ-035 While rst=1 at a rising edge, the state SHALL go to IDLE and the result register to 0.
REQ-036 After reset, mem_req, mem_we, mem_wstrb, stallM and misalignM SHALL read 0 in the next cycle.
REQ-037 A reset during BUSY SHALL abandon the request, with mem_req=0 in the next cycle; a late mem_ready SHALL be ignored.

Structure
REQ-038 The memctrl encodings, the FSM state enum and the WD/WAM defaults SHALL reside in shared package mem_pkg.
REQ-039 Lane extraction and extension SHALL be one combinational sub-module, load_align.

Verification
REQ-040 LW at 0x100 with mem_ready on the first BUSY cycle and rdata=0xDEADBEEF SHALL give stall for 2 cycles, then readdataM=0xDEADBEEF in DONE.
REQ-041 LB at 0x103 with rdata=0x80FF_0000 SHALL give readdataM=0xFFFFFF80; LBU at the same address SHALL give 0x00000080.
REQ-042 SH at 0x102 with data 0x1234ABCD SHALL drive wstrb=1100 and wdata=0xABCDABCD; mem_ready delayed 3 cycles SHALL give 5 stall cycles in total.
REQ-043 LW at 0x101 SHALL give misalignM=1, stallM=0, and mem_req never asserted.
REQ-044 rst asserted in the second BUSY cycle, followed by mem_ready one cycle later, SHALL give IDLE, mem_req=0 and readdataM=0.
